// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the multi-cycle MULT/MULTU/DIV/DIVU sequencer.
//   muldiv_op_e     : 2-bit opcode as presented on the sequencer's op input
//   muldiv_state_e  : sequencer FSM states
//   MULDIV_ITERS    : shift-add / shift-subtract iterations per operation
//   MULDIV_LAT      : cycles from the accepting edge to the DONE cycle
//   MULDIV_DZ_LO    : LO value produced by a divide by zero
// -----------------------------------------------------------------------------
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } muldiv_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP_A,
      ST_PREP_B,
      ST_ITER,
      ST_FIX_LO,
      ST_FIX_HI,
      ST_DONE
   } muldiv_state_e;

   localparam int          MULDIV_ITERS = 32;
   localparam int          MULDIV_LAT   = 37;
   localparam logic [31:0] MULDIV_DZ_LO = 32'hFFFF_FFFF;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_seq_add.sv
// -----------------------------------------------------------------------------
// muldiv_seq_add
// The single 32-bit ADD shared by every step of the sequencer.
//   a, b  in  32 : addends
//   cin   in  1  : carry in
//   sum   out 32 : a + b + cin (low 32 bits)
//   cout  out 1  : carry out of bit 31
// -----------------------------------------------------------------------------
module muldiv_seq_add (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   assign sum  = a + b + {31'd0, cin};
   // Carry out recovered from the top bits: generate, or propagate with no
   // visible carry left in bit 31 of the result.
   assign cout = (a[31] & b[31]) | ((a[31] | b[31]) & ~sum[31]);

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. Owns HI/LO and time-shares
// one 32-bit adder across operand magnitude preparation, 32 shift-add or
// restoring shift-subtract iterations, and the final sign fix-up. Latency is
// fixed: every state runs whether or not it has work to do.
//
// Ports
//   clk     in  1  : rising-edge clock
//   rst     in  1  : asynchronous active-high reset
//   start   in  1  : request strobe, honoured only in IDLE
//   op      in  2  : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   rs_val  in  32 : multiplicand / dividend
//   rt_val  in  32 : multiplier / divisor
//   busy    out 1  : high whenever the FSM is not IDLE
//   done    out 1  : one-cycle pulse in DONE
//   hi      out 32 : product high word / remainder
//   lo      out 32 : product low word / quotient
//
// Configuration
//   MULDIV_DIV_EN : when defined, divide support is built. When undefined a
//                   DIV/DIVU start goes straight to DONE and leaves HI/LO alone.
// -----------------------------------------------------------------------------
module muldiv_seq
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [4:0] ITER_LAST = 5'(MULDIV_ITERS - 1);

   muldiv_state_e state_q, state_d;
   logic [4:0]    cnt_q;
   logic          signed_q;
   logic [31:0]   a_q;          // rs, then |rs|
   logic [31:0]   b_q;          // rt, then |rt|
   logic [31:0]   hi_q, lo_q;
   logic          neg_quo_q;
   logic          fix_carry_q;  // carry from negating LO into HI
`ifdef MULDIV_DIV_EN
   logic          div_q;
   logic          neg_rem_q;
   logic          div_zero_q;
   logic [31:0]   shifted_hi;
   logic          q_bit;
`endif

   logic [31:0]   add_a, add_b, add_sum;
   logic          add_cin, add_cout;
   logic [31:0]   b_mag;

   muldiv_seq_add u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // In PREP_B the adder holds -rt, so this is |rt| for signed ops.
   assign b_mag = (signed_q && b_q[31]) ? add_sum : b_q;

`ifdef MULDIV_DIV_EN
   // Partial remainder shifted left; hi_q[31] is its 33rd bit.
   assign shifted_hi = {hi_q[30:0], lo_q[31]};
   assign q_bit      = hi_q[31] | add_cout;
`endif

   // ---------------------------------------------------------------- FSM ---
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
`ifdef MULDIV_DIV_EN
               state_d = ST_PREP_A;
`else
               state_d = op_is_div(op) ? ST_DONE : ST_PREP_A;
`endif
            end
         end
         ST_PREP_A: begin
            add_a   = ~a_q;
            add_cin = 1'b1;
            state_d = ST_PREP_B;
         end
         ST_PREP_B: begin
            add_a   = ~b_q;
            add_cin = 1'b1;
            state_d = ST_ITER;
         end
         ST_ITER: begin
`ifdef MULDIV_DIV_EN
            if (div_q) begin
               add_a   = shifted_hi;
               add_b   = ~b_q;
               add_cin = 1'b1;
            end else
`endif
            begin
               add_a = hi_q;
               add_b = lo_q[0] ? a_q : '0;
            end
            if (cnt_q == ITER_LAST) state_d = ST_FIX_LO;
         end
         ST_FIX_LO: begin
            add_a   = ~lo_q;
            add_cin = 1'b1;
            state_d = ST_FIX_HI;
         end
         ST_FIX_HI: begin
            add_a = ~hi_q;
`ifdef MULDIV_DIV_EN
            add_cin = div_q ? 1'b1 : fix_carry_q;
`else
            add_cin = fix_carry_q;
`endif
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath ---
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         signed_q    <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         neg_quo_q   <= 1'b0;
         fix_carry_q <= 1'b0;
`ifdef MULDIV_DIV_EN
         div_q       <= 1'b0;
         neg_rem_q   <= 1'b0;
         div_zero_q  <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  signed_q  <= op_is_signed(op);
                  a_q       <= rs_val;
                  b_q       <= rt_val;
                  neg_quo_q <= op_is_signed(op) & (rs_val[31] ^ rt_val[31]);
`ifdef MULDIV_DIV_EN
                  div_q      <= op_is_div(op);
                  neg_rem_q  <= op_is_signed(op) & rs_val[31];
                  div_zero_q <= op_is_div(op) && (rt_val == '0);
`endif
               end
            end
            ST_PREP_A: begin
               if (signed_q && a_q[31]) a_q <= add_sum;
            end
            ST_PREP_B: begin
               b_q  <= b_mag;
               hi_q <= '0;
`ifdef MULDIV_DIV_EN
               lo_q <= div_q ? a_q : b_mag;
`else
               lo_q <= b_mag;
`endif
            end
            ST_ITER: begin
               cnt_q <= cnt_q + 5'd1;   // wraps to 0 as ITER is left
`ifdef MULDIV_DIV_EN
               if (div_q) begin
                  hi_q <= q_bit ? add_sum : shifted_hi;
                  lo_q <= {lo_q[30:0], q_bit};
               end else
`endif
               begin
                  hi_q <= {add_cout, add_sum[31:1]};
                  lo_q <= {add_sum[0], lo_q[31:1]};
               end
            end
            ST_FIX_LO: begin
               if (neg_quo_q) begin
                  lo_q        <= add_sum;
                  fix_carry_q <= (lo_q == '0);
               end
            end
            ST_FIX_HI: begin
`ifdef MULDIV_DIV_EN
               if (div_q) begin
                  // With a zero divisor every step subtracts zero, so HI ends
                  // at |rs| and the remainder sign fix restores the original rs.
                  if (neg_rem_q)  hi_q <= add_sum;
                  if (div_zero_q) lo_q <= MULDIV_DZ_LO;
               end else
`endif
               begin
                  if (neg_quo_q) hi_q <= add_sum;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Directed self-checking bench for muldiv_seq. Divide scenarios are selected by
// MULDIV_DIV_EN to match the build of the design.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val, rt_val;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   muldiv_seq dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // Strobe one request and observe a fixed window of MULDIV_LAT+2 cycles.
   // Cycle k is the k-th falling edge after the accepting rising edge.
   // glitch_cyc > 0 raises start with unrelated operands during that cycle.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int glitch_cyc, output int done_cyc, output int done_cnt,
                         output int busy_low, output logic [31:0] hi_d, output logic [31:0] lo_d);
      done_cyc = 0;
      done_cnt = 0;
      busy_low = 0;
      hi_d     = 'x;
      lo_d     = 'x;
      @(negedge clk);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      for (int k = 1; k <= MULDIV_LAT + 2; k++) begin
         @(negedge clk);
         start = (k == glitch_cyc);
         if (k == glitch_cyc) begin
            op     = ~o;
            rs_val = ~a;
            rt_val = 32'h0000_0001;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) begin
               done_cyc = k;
               hi_d     = hi;
               lo_d     = lo;
            end
         end
         if (!busy && busy_low == 0) busy_low = k;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: busy=%b done=%b, required 0 0", busy, done);
      end
      checks++;
      if (hi !== 32'h0 || lo !== 32'h0) begin
         errors++;
         $display("FAIL reset_hilo: hi=%h lo=%h, required 0 0", hi, lo);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_multiply();
      vec_t v[5];
      int dc, dn, bl;
      logic [31:0] h, l;
      v[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      v[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      v[2] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      v[3] = '{OP_MULT,  32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000};
      v[4] = '{OP_MULTU, 32'h8000_0000, 32'h0000_0003, 32'h0000_0001, 32'h8000_0000};
      for (int i = 0; i < 5; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, 0, dc, dn, bl, h, l);
         checks++;
         if (dc !== MULDIV_LAT || dn !== 1 || bl !== MULDIV_LAT + 1) begin
            errors++;
            $display("FAIL mul[%0d] timing: done_cycle=%0d done_count=%0d busy_low=%0d, required %0d 1 %0d",
                     i, dc, dn, bl, MULDIV_LAT, MULDIV_LAT + 1);
         end
         checks++;
         if (h !== v[i].hi || l !== v[i].lo) begin
            errors++;
            $display("FAIL mul[%0d] result: hi=%h lo=%h, required hi=%h lo=%h", i, h, l, v[i].hi, v[i].lo);
         end
      end
      checks++;
      if (hi !== v[4].hi || lo !== v[4].lo) begin
         errors++;
         $display("FAIL mul_hold: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, v[4].hi, v[4].lo);
      end
   endtask

`ifdef MULDIV_DIV_EN
   task automatic test_divide();
      vec_t v[7];
      int dc, dn, bl;
      logic [31:0] h, l;
      v[0] = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      v[1] = '{OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
      v[2] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      v[3] = '{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      v[4] = '{OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001};
      v[5] = '{OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
      v[6] = '{OP_DIV,  32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
      for (int i = 0; i < 7; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, 0, dc, dn, bl, h, l);
         checks++;
         if (dc !== MULDIV_LAT || dn !== 1 || bl !== MULDIV_LAT + 1) begin
            errors++;
            $display("FAIL div[%0d] timing: done_cycle=%0d done_count=%0d busy_low=%0d, required %0d 1 %0d",
                     i, dc, dn, bl, MULDIV_LAT, MULDIV_LAT + 1);
         end
         checks++;
         if (h !== v[i].hi || l !== v[i].lo) begin
            errors++;
            $display("FAIL div[%0d] result: hi=%h lo=%h, required hi=%h lo=%h", i, h, l, v[i].hi, v[i].lo);
         end
      end
   endtask
`else
   task automatic test_div_disabled();
      int dc, dn, bl;
      logic [31:0] h, l;
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 0, dc, dn, bl, h, l);
      checks++;
      if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
         errors++;
         $display("FAIL nodiv_pre: hi=%h lo=%h, required hi=ffffffff lo=ffffffeb", h, l);
      end
      run_op(OP_DIVU, 32'h0000_0064, 32'h0000_0007, 0, dc, dn, bl, h, l);
      checks++;
      if (dc !== 1 || dn !== 1 || bl !== 2) begin
         errors++;
         $display("FAIL nodiv_timing: done_cycle=%0d done_count=%0d busy_low=%0d, required 1 1 2",
                  dc, dn, bl);
      end
      checks++;
      if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
         errors++;
         $display("FAIL nodiv_hilo: hi=%h lo=%h (at done %h %h), required hi=ffffffff lo=ffffffeb",
                  hi, lo, h, l);
      end
   endtask
`endif

   task automatic test_start_ignored();
      int dc, dn, bl;
      logic [31:0] h, l;
      run_op(OP_MULTU, 32'h0001_0001, 32'h0000_FFFF, 5, dc, dn, bl, h, l);
      checks++;
      if (dc !== MULDIV_LAT || dn !== 1 || bl !== MULDIV_LAT + 1) begin
         errors++;
         $display("FAIL busy_start timing: done_cycle=%0d done_count=%0d busy_low=%0d, required %0d 1 %0d",
                  dc, dn, bl, MULDIV_LAT, MULDIV_LAT + 1);
      end
      checks++;
      if (h !== 32'h0000_0000 || l !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL busy_start result: hi=%h lo=%h, required hi=00000000 lo=ffffffff", h, l);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_start idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_reset_mid_op();
      int dc, dn, bl;
      logic [31:0] h, l;
      logic busy_before;
      busy_before = 1'b0;
      @(negedge clk);
      start  = 1'b1;
      op     = OP_MULTU;
      rs_val = 32'hFFFF_FFFF;
      rt_val = 32'hFFFF_FFFF;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 9) busy_before = busy;
      end
      rst = 1'b1;
      #1;
      checks++;
      if (busy_before !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre: busy=%b before reset, required 1", busy_before);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         errors++;
         $display("FAIL midrst_clear: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(OP_MULTU, 32'h0000_1234, 32'h0000_0010, 0, dc, dn, bl, h, l);
      checks++;
      if (dc !== MULDIV_LAT || dn !== 1 || bl !== MULDIV_LAT + 1) begin
         errors++;
         $display("FAIL midrst_after timing: done_cycle=%0d done_count=%0d busy_low=%0d, required %0d 1 %0d",
                  dc, dn, bl, MULDIV_LAT, MULDIV_LAT + 1);
      end
      checks++;
      if (h !== 32'h0000_0000 || l !== 32'h0001_2340) begin
         errors++;
         $display("FAIL midrst_after result: hi=%h lo=%h, required hi=00000000 lo=00012340", h, l);
      end
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      rs_val = '0;
      rt_val = '0;
      test_reset();
      test_multiply();
`ifdef MULDIV_DIV_EN
      test_divide();
`else
      test_div_disabled();
`endif
      test_start_ignored();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
